writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage, directly downstream of the memory stage. Latches the instruction
//  and branch tag handed on by the memory stage and squashes wrong-path work by tag compare.
//  Commits LDR read data to register-file write port 2, exposes the same write as a
//  forwarding source, and counts retired instructions.
// PARAMETERS
//  CNT_W  16  width of retired_count (wraps modulo 2**CNT_W)
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst_n          in   1       asynchronous active-low reset
//  instr_in       in   32      instruction from memory stage (instr_output there)
//  branch_in      in   1       branch tag travelling with instr_in
//  branch_ref     in   1       global branch reference (branch_ref_global)
//  stall          in   1       hold stage contents this cycle
//  mem_rdata      in   32      data RAM read data for the instruction held in this stage
//  instr_output   out  32      held instruction, NOP when squashed
//  w_en2          out  1       register-file port-2 write enable
//  w_addr2        out  4       port-2 write address (Rd)
//  w_data2        out  32      port-2 write data
//  fwd_valid      out  1       forwarding source valid (== w_en2)
//  fwd_addr       out  4       == w_addr2
//  fwd_data       out  32      == w_data2
//  retired_count  out  CNT_W   live instructions retired since reset
// BEHAVIOUR
//  Fields: cond=instr[31:28], opcode=instr[27:21], rd=instr[15:12]. NOP = 32'hF000_0000.
//  Classes (decode of held instr):
//   - NOP: cond==4'b1111.
//   - LDR: opcode[6:5]==2'b11 or opcode[6:3]==4'b1000, with opcode[4]==0.
//   - STR: same opcode match, with opcode[4]==1.
//   - Other: anything else.
//  State: instr_reg, tag_reg, done, hold_valid, hold_data[31:0], retired_count.
//  Reset (async, any time, incl. mid-stall): instr_reg=NOP, tag_reg=0, done=0, hold_valid=0,
//   hold_data=0, retired_count=0.
//   -> Outputs: instr_output=NOP, w_en2=0, w_addr2=0, w_data2=0, fwd_*=0.
//  Capture: if !stall, instr_reg<=instr_in, tag_reg<=branch_in, done<=0, hold_valid<=0.
//   Latency 1 cycle memory->writeback. If stall, instr_reg/tag_reg hold.
//  live = (tag_reg==branch_ref) && cond!=4'b1111, combinational every cycle.
//   - !live: instr_output=NOP, no write.
//   - live: instr_output=instr_reg.
//  One-shot commit: fire = live && !done. On a fire cycle with stall=1, done<=1.
//   - w_en2 = fire && LDR.
//   - w_addr2 = rd when w_en2, else 0. R15 is written like any other register.
//   - w_data2 = hold_valid ? hold_data : mem_rdata; forced 0 when !w_en2.
//   - STR/other/NOP never write port 2; Rn/link writes are the memory stage's job.
//  Stall data hold: on the first stalled cycle of an LDR (hold_valid==0),
//   hold_data<=mem_rdata, hold_valid<=1. Later stalled cycles keep hold_data.
//  retired_count: +1 on every fire cycle (any non-NOP live class), wraps all-ones -> 0.
//  Simultaneous events:
//   - branch_ref toggles in the same cycle as a fire: live is evaluated that cycle;
//     a squashed instruction never fires.
//   - Already-fired instruction later squashed during stall: write stands, count stands.
//   - Squashed-then-stall-released: new instruction captured normally.
// TESTING
//  1. Reset then LDR r3 (tag=0, ref=0), mem_rdata=32'hDEAD_BEEF
//     -> next cycle w_en2=1, w_addr2=3, w_data2=DEADBEEF, retired_count=1.
//  2. LDR r5, tag=1, ref=0 -> w_en2=0, instr_output=32'hF000_0000, retired_count unchanged.
//  3. LDR r2 with stall=1 for 3 cycles, mem_rdata 11->22->33 -> w_en2=1 only first cycle,
//     data 32'h11; retired_count +1 once.
//  4. ADD then STR back-to-back, both live -> w_en2=0 both; retired_count +2.
//  5. CNT_W=4, 16 live instrs from 0 -> retired_count returns to 0.
//  6. rst_n low mid-stall with hold_valid=1 -> all outputs 0/NOP immediately, count=0.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Bundle between the memory stage and writeback: the held instruction in, and the
// register-file port-2 write / forwarding source out.
interface writeback_unit_if;
  logic [31:0] instr_in;
  logic        branch_in;
  logic        branch_ref;
  logic        stall;
  logic [31:0] mem_rdata;
  logic [31:0] instr_output;
  logic        w_en2;
  logic [3:0]  w_addr2;
  logic [31:0] w_data2;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;

  modport master (
    output instr_in, branch_in, branch_ref, stall, mem_rdata,
    input  instr_output, w_en2, w_addr2, w_data2, fwd_valid, fwd_addr, fwd_data
  );

  modport slave (
    input  instr_in, branch_in, branch_ref, stall, mem_rdata,
    output instr_output, w_en2, w_addr2, w_data2, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: holds the instruction from the memory stage, squashes wrong-path
// work by branch-tag compare, commits LDR data on port 2 once, and counts retirements.
module writeback_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  wb,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [31:0] NOP = 32'hF000_0000;

  logic [31:0] instr_reg;
  logic        tag_reg;
  logic        done;
  logic        hold_valid;
  logic [31:0] hold_data;

  logic [3:0]  cond;
  logic [6:0]  opcode;
  logic [3:0]  rd;
  logic        mem_op;
  logic        is_ldr;
  logic        live;
  logic        fire;
  logic        wr_en;

  assign cond   = instr_reg[31:28];
  assign opcode = instr_reg[27:21];
  assign rd     = instr_reg[15:12];
  assign mem_op = (opcode[6:5] == 2'b11) || (opcode[6:3] == 4'b1000);
  assign is_ldr = (cond != 4'b1111) && mem_op && !opcode[4];

  // A held instruction commits at most once, even across a multi-cycle stall.
  assign live  = (tag_reg == wb.branch_ref) && (cond != 4'b1111);
  assign fire  = live && !done;
  assign wr_en = fire && is_ldr;

  assign wb.instr_output = live ? instr_reg : NOP;
  assign wb.w_en2        = wr_en;
  assign wb.w_addr2      = wr_en ? rd : 4'd0;
  assign wb.w_data2      = wr_en ? (hold_valid ? hold_data : wb.mem_rdata) : 32'd0;
  assign wb.fwd_valid    = wr_en;
  assign wb.fwd_addr     = wb.w_addr2;
  assign wb.fwd_data     = wb.w_data2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg  <= NOP;
      tag_reg    <= 1'b0;
      done       <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
    end else if (!wb.stall) begin
      instr_reg  <= wb.instr_in;
      tag_reg    <= wb.branch_in;
      done       <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (fire)
        done <= 1'b1;
      // The RAM may move on during a stall; keep the data seen on the first stalled cycle.
      if (is_ldr && !hold_valid) begin
        hold_data  <= wb.mem_rdata;
        hold_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_count <= '0;
    else if (fire)
      retired_count <= retired_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: per-cycle expectations are queued when stimulus is
// driven and popped when the outputs for that cycle are sampled.
module tb_writeback_unit;

  localparam logic [31:0] NOP  = 32'hF000_0000;
  localparam logic [31:0] LDR  = 32'hEC00_0000;
  localparam logic [31:0] LDRB = 32'hE800_0000;
  localparam logic [31:0] STR  = 32'hEE00_0000;
  localparam logic [31:0] ADD  = 32'hE080_0000;

  typedef struct {
    logic        en;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] instr;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] retired_count;
  logic [3:0]  retired_count4;
  exp_t        expQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;

  writeback_unit_if wb ();
  writeback_unit_if wb4 ();

  assign wb4.instr_in   = wb.instr_in;
  assign wb4.branch_in  = wb.branch_in;
  assign wb4.branch_ref = wb.branch_ref;
  assign wb4.stall      = wb.stall;
  assign wb4.mem_rdata  = wb.mem_rdata;

  writeback_unit #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb.slave),
    .retired_count (retired_count)
  );

  writeback_unit #(.CNT_W(4)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb4.slave),
    .retired_count (retired_count4)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    #2;
    if (expQ.size() == 0) begin
      checkField("queue_empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkField("w_en2",         {31'd0, wb.w_en2},        {31'd0, e.en});
      checkField("w_addr2",       {28'd0, wb.w_addr2},      {28'd0, e.addr});
      checkField("w_data2",       wb.w_data2,               e.data);
      checkField("instr_output",  wb.instr_output,          e.instr);
      checkField("fwd_valid",     {31'd0, wb.fwd_valid},    {31'd0, e.en});
      checkField("fwd_addr",      {28'd0, wb.fwd_addr},     {28'd0, e.addr});
      checkField("fwd_data",      wb.fwd_data,              e.data);
      checkField("retired_count", {16'd0, retired_count},   {16'd0, e.cnt});
      checkField("retired_cnt4",  {28'd0, retired_count4},  {28'd0, e.cnt[3:0]});
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ii, input logic bi, input logic st,
                               input logic br, input logic [31:0] rdat,
                               input logic eEn, input logic [3:0] eAddr,
                               input logic [31:0] eData, input logic [31:0] eInstr,
                               input int eCnt);
    exp_t e;
    @(negedge clk);
    wb.instr_in   = ii;
    wb.branch_in  = bi;
    wb.stall      = st;
    wb.branch_ref = br;
    wb.mem_rdata  = rdat;
    e.en    = eEn;
    e.addr  = eAddr;
    e.data  = eData;
    e.instr = eInstr;
    e.cnt   = 16'(eCnt);
    expQ.push_back(e);
    checkOutput();
  endtask

  initial begin
    exp_t e;
    wb.instr_in   = NOP;
    wb.branch_in  = 1'b0;
    wb.stall      = 1'b0;
    wb.branch_ref = 1'b0;
    wb.mem_rdata  = 32'd0;
    $display("[TB] reset");
    repeat (2) @(posedge clk);
    applyStimulus(NOP, 0, 0, 0, 32'h0, 0, 4'd0, 32'h0, NOP, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic LDR, squash, stalled LDR");
    applyStimulus(LDR | 32'h3000, 0, 0, 0, 32'h0,          0, 4'd0,  32'h0,         NOP,            0);
    applyStimulus(LDR | 32'h5000, 1, 0, 0, 32'hDEAD_BEEF,  1, 4'd3,  32'hDEAD_BEEF, LDR | 32'h3000, 0);
    applyStimulus(LDR | 32'h2000, 0, 0, 0, 32'h1234_5678,  0, 4'd0,  32'h0,         NOP,            1);
    applyStimulus(ADD | 32'h1000, 0, 1, 0, 32'h11,         1, 4'd2,  32'h11,        LDR | 32'h2000, 1);
    applyStimulus(ADD | 32'h1000, 0, 1, 0, 32'h22,         0, 4'd0,  32'h0,         LDR | 32'h2000, 2);
    applyStimulus(ADD | 32'h1000, 0, 0, 0, 32'h33,         0, 4'd0,  32'h0,         LDR | 32'h2000, 2);

    $display("[TB] ADD/STR retire without write, R15 and alternate LDR encoding");
    applyStimulus(STR | 32'h4000, 0, 0, 0, 32'h44,         0, 4'd0,  32'h0,         ADD | 32'h1000, 2);
    applyStimulus(LDR | 32'hF000, 0, 0, 0, 32'h55,         0, 4'd0,  32'h0,         STR | 32'h4000, 3);
    applyStimulus(LDRB | 32'h7000, 0, 0, 0, 32'hCAFE_F00D, 1, 4'd15, 32'hCAFE_F00D, LDR | 32'hF000, 4);
    applyStimulus(NOP,            0, 0, 0, 32'h0000_ABCD,  1, 4'd7,  32'h0000_ABCD, LDRB | 32'h7000, 5);

    $display("[TB] squash during stall, ref toggle, held data");
    applyStimulus(LDR | 32'h6000, 1, 0, 0, 32'h1,          0, 4'd0,  32'h0,         NOP,            6);
    applyStimulus(LDR | 32'h9000, 0, 1, 0, 32'h77,         0, 4'd0,  32'h0,         NOP,            6);
    applyStimulus(LDR | 32'h9000, 0, 1, 1, 32'h88,         1, 4'd6,  32'h77,        LDR | 32'h6000, 6);
    applyStimulus(LDR | 32'h9000, 0, 0, 0, 32'h99,         0, 4'd0,  32'h0,         NOP,            7);
    applyStimulus(NOP,            0, 0, 0, 32'h0BAD_F00D,  1, 4'd9,  32'h0BAD_F00D, LDR | 32'h9000, 7);

    $display("[TB] counter wrap on narrow instance");
    applyStimulus(ADD, 0, 0, 0, 32'h0, 0, 4'd0, 32'h0, NOP, 8);
    for (int k = 0; k < 8; k++)
      applyStimulus(ADD, 0, 0, 0, 32'h0, 0, 4'd0, 32'h0, ADD, 8 + k);
    applyStimulus(NOP, 0, 0, 0, 32'h0, 0, 4'd0, 32'h0, ADD, 16);

    $display("[TB] reset in the middle of a stall");
    applyStimulus(LDR | 32'h8000, 0, 0, 0, 32'h0,         0, 4'd0, 32'h0,         NOP,            17);
    applyStimulus(ADD,            0, 1, 0, 32'hAAAA_5555, 1, 4'd8, 32'hAAAA_5555, LDR | 32'h8000, 17);
    applyStimulus(ADD,            0, 1, 0, 32'h0,         0, 4'd0, 32'h0,         LDR | 32'h8000, 18);
    rst_n = 1'b0;
    #1;
    e.en = 1'b0; e.addr = 4'd0; e.data = 32'h0; e.instr = NOP; e.cnt = 16'd0;
    expQ.push_back(e);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(LDR | 32'h1000, 0, 0, 0, 32'h0,         0, 4'd0, 32'h0,         NOP,            0);
    applyStimulus(NOP,            0, 0, 0, 32'h5A5A_5A5A, 1, 4'd1, 32'h5A5A_5A5A, LDR | 32'h1000, 0);
    applyStimulus(NOP,            0, 0, 0, 32'h0,         0, 4'd0, 32'h0,         NOP,            1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
